// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave.
//   SYNC_STAGES : flop count per input (two metastability stages + one
//                 history flop for edge detection)
//   spi_state_e : frame state of the slave
package spi_pkg;

   localparam int SYNC_STAGES = 3;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_slave_mode_sync_edge.sv
// sync_edge: brings one asynchronous input into the clk domain and flags
// its edges.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
module sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= {SYNC_STAGES{RST_VAL}};
      else     sr <= {sr[SYNC_STAGES-2:0], d};
   end

   // sr[SYNC_STAGES-2] is the last synchroniser stage; the top bit is its
   // one-cycle history, used only for edge detection.
   assign q    = sr[SYNC_STAGES-2];
   assign rise =  sr[SYNC_STAGES-2] & ~sr[SYNC_STAGES-1];
   assign fall = ~sr[SYNC_STAGES-2] &  sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_mode.sv
// spi_slave_mode: oversampled SPI slave, all four SPI modes.
//   clk, rst          : system clock, synchronous active-high reset
//   sck, mosi, ssel   : SPI pins (asynchronous, ssel active low)
//   miso, miso_oe     : SPI data out and its enable (high while in a frame)
//   rx_data, rx_valid : last complete received word and its update strobe
//   tx_data, tx_valid,
//   tx_ready          : valid/ready load of the single-word holding register
//   tx_underrun       : strobe, a word started with the holding register empty
//   frame_end         : strobe, ssel deasserted while in a frame
module spi_slave_mode
   import spi_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sck,
   input  logic             mosi,
   input  logic             ssel,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic             frame_end
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic sck_q, sck_rise, sck_fall;
   logic mosi_q, mosi_rise, mosi_fall;
   logic ssel_q, ssel_rise, ssel_fall;
   logic unused_sync;

   // sck resets to its idle level; ssel resets low so a reset taken in the
   // middle of a frame cannot fake a select edge and restart that frame.
   sync_edge #(.RST_VAL(1'(CPOL))) u_sync_sck (
      .clk(clk), .rst(rst), .d(sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
   sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
   sync_edge #(.RST_VAL(1'b0)) u_sync_ssel (
      .clk(clk), .rst(rst), .d(ssel), .q(ssel_q), .rise(ssel_rise), .fall(ssel_fall));

   assign unused_sync = ^{sck_q, mosi_rise, mosi_fall, ssel_q};

   logic sample_edge, shift_edge;
   assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
   assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;

   spi_state_e       state;
   logic [CW-1:0]    bitcnt;
   logic [WIDTH-1:0] rx_shift, rx_next;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             wrap_pend;    // next shift edge starts a new word
   logic             commit_pend;  // CPHA=0: word preloaded, not yet committed
   logic             commit_full;  // holding register state at preload time
   logic             end_pend;     // delays frame_end behind a final rx_valid

   always_comb begin
      rx_next = (MSB_FIRST != 0) ? {rx_shift[WIDTH-2:0], mosi_q}
                                 : {mosi_q, rx_shift[WIDTH-1:1]};
   end

   assign tx_ready = ~hold_full;
   assign miso_oe  = (state == ST_ACTIVE);
   assign miso     = (state != ST_ACTIVE) ? 1'b0 :
                     (MSB_FIRST != 0)     ? tx_shift[WIDTH-1] : tx_shift[0];

   always_ff @(posedge clk) begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      end_pend    <= 1'b0;
      frame_end   <= end_pend;
      if (rst) begin
         state       <= ST_IDLE;
         bitcnt      <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         rx_data     <= '0;
         wrap_pend   <= 1'b0;
         commit_pend <= 1'b0;
         commit_full <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (ssel_fall) begin
                  state       <= ST_ACTIVE;
                  bitcnt      <= '0;
                  commit_pend <= 1'b0;
                  // CPHA=1 loads on the first leading edge instead of here.
                  wrap_pend   <= (CPHA != 0);
                  if (CPHA == 0) begin
                     if (hold_full) begin
                        tx_shift  <= hold_data;
                        hold_full <= 1'b0;
                     end else begin
                        tx_shift    <= '0;
                        tx_underrun <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (sample_edge) begin
                  rx_shift <= rx_next;
                  if (bitcnt == LAST) begin
                     bitcnt    <= '0;
                     rx_data   <= rx_next;
                     rx_valid  <= 1'b1;
                     wrap_pend <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + CW'(1);
                  end
                  // First sample of a preloaded CPHA=0 word: the word really
                  // started, so consume the holding register or flag underrun.
                  if (commit_pend) begin
                     commit_pend <= 1'b0;
                     if (commit_full) hold_full   <= 1'b0;
                     else             tx_underrun <= 1'b1;
                  end
               end
               if (shift_edge) begin
                  if (wrap_pend) begin
                     wrap_pend <= 1'b0;
                     tx_shift  <= hold_full ? hold_data : '0;
                     if (CPHA == 0) begin
                        // Trailing edge of the previous word: the master may
                        // end the frame here, so only peek at the holding
                        // register and commit on the next sample edge.
                        commit_pend <= 1'b1;
                        commit_full <= hold_full;
                     end else if (hold_full) begin
                        hold_full <= 1'b0;
                     end else begin
                        tx_underrun <= 1'b1;
                     end
                  end else begin
                     tx_shift <= (MSB_FIRST != 0) ? {tx_shift[WIDTH-2:0], 1'b0}
                                                  : {1'b0, tx_shift[WIDTH-1:1]};
                  end
               end
               // Any partial word is dropped; the holding register is kept.
               if (ssel_rise) begin
                  state       <= ST_IDLE;
                  bitcnt      <= '0;
                  wrap_pend   <= 1'b0;
                  commit_pend <= 1'b0;
                  end_pend    <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench: four WIDTH=8 instances (SPI modes 0..3, index = mode) and
// one WIDTH=16 LSB-first mode-0 instance (index 4), driven one at a time.
module tb_spi_slave_mode;

   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] sck, mosi, ssel;
   logic [4:0] miso, miso_oe, rx_valid, tx_valid, tx_ready, tx_underrun, frame_end;
   logic [7:0] rxd8 [4];
   logic [7:0] txd8 [4];
   logic [15:0] rxd16, txd16;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int rxv_cnt [5];
   int fe_cnt  [5];
   int ur_cnt  [5];
   int last_rxv_cyc [5];
   int last_fe_cyc  [5];
   int s_rxv, s_fe, s_ur;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_w8
      spi_slave_mode #(.WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1)) u_dut (
         .clk(clk), .rst(rst), .sck(sck[g]), .mosi(mosi[g]), .ssel(ssel[g]),
         .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rxd8[g]), .rx_valid(rx_valid[g]),
         .tx_data(txd8[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
         .tx_underrun(tx_underrun[g]), .frame_end(frame_end[g]));
   end

   spi_slave_mode #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_dut16 (
      .clk(clk), .rst(rst), .sck(sck[4]), .mosi(mosi[4]), .ssel(ssel[4]),
      .miso(miso[4]), .miso_oe(miso_oe[4]), .rx_data(rxd16), .rx_valid(rx_valid[4]),
      .tx_data(txd16), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
      .tx_underrun(tx_underrun[4]), .frame_end(frame_end[4]));

   // strobe counters
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int m = 0; m < 5; m++) begin
         if (rx_valid[m])    begin rxv_cnt[m] <= rxv_cnt[m] + 1; last_rxv_cyc[m] <= cyc; end
         if (frame_end[m])   begin fe_cnt[m]  <= fe_cnt[m] + 1;  last_fe_cyc[m]  <= cyc; end
         if (tx_underrun[m]) ur_cnt[m] <= ur_cnt[m] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rx_of(input int m);
      if (m < 4) return {8'h00, rxd8[m]};
      return rxd16;
   endfunction

   task automatic snap(input int m);
      s_rxv = rxv_cnt[m];
      s_fe  = fe_cnt[m];
      s_ur  = ur_cnt[m];
   endtask

   task automatic push_tx(input int m, input logic [15:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      if (m < 4) txd8[m] = d[7:0];
      else       txd16   = d;
      tx_valid[m] = 1'b1;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (tx_ready[m]) ok = 1'b1;
         @(negedge clk);
      end
      tx_valid[m] = 1'b0;
      chk("push_ack", 32'(ok), 32'd1);
   endtask

   task automatic ssel_low(input int m);
      ssel[m] = 1'b0;
      #(2 * HALF);
   endtask

   task automatic ssel_high(input int m);
      #(HALF);
      ssel[m] = 1'b1;
      #(HALF);
      repeat (10) @(negedge clk);
   endtask

   // Master side of nbits bit-times; returns what it sampled from miso.
   task automatic spi_word(input int m, input logic [15:0] txw, input int nbits,
                           output logic [15:0] rxw);
      logic c;
      int   w, b;
      bit   ph, msb;
      c   = (m == 2 || m == 3);
      ph  = (m == 1 || m == 3);
      msb = (m != 4);
      w   = (m == 4) ? 16 : 8;
      rxw = '0;
      for (int i = 0; i < nbits; i++) begin
         b = msb ? (w - 1 - i) : i;
         if (!ph) begin
            mosi[m] = txw[b];
            #(HALF);
            sck[m] = ~c;
            rxw[b] = miso[m];
            #(HALF);
            sck[m] = c;
         end else begin
            sck[m]  = ~c;
            mosi[m] = txw[b];
            #(HALF);
            sck[m] = c;
            rxw[b] = miso[m];
            #(HALF);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got, got2;
      string       nm;
      for (int m = 0; m < 5; m++) begin
         rxv_cnt[m] = 0; fe_cnt[m] = 0; ur_cnt[m] = 0;
         last_rxv_cyc[m] = 0; last_fe_cyc[m] = 0;
      end
      for (int m = 0; m < 4; m++) txd8[m] = 8'h00;
      txd16    = 16'h0000;
      tx_valid = '0;
      sck      = 5'b01100;
      mosi     = '0;
      ssel     = '1;
      rst      = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_tx_ready", 32'(tx_ready), 32'h1F);
      chk("rst_miso_oe",  32'(miso_oe),  32'h0);
      chk("rst_miso",     32'(miso),     32'h0);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_strobes",  32'({tx_underrun, frame_end}), 32'h0);
      chk("rst_rx_data0", 32'(rx_of(0)), 32'h0);
      chk("rst_rx_data16", 32'(rx_of(4)), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // one word in each mode: rx 0xA5, tx 0x3C
      for (int m = 0; m < 4; m++) begin
         nm = $sformatf("m%0d", m);
         push_tx(m, 16'h003C);
         snap(m);
         ssel_low(m);
         chk({nm, "_miso_oe"}, 32'(miso_oe[m]), 32'd1);
         spi_word(m, 16'h00A5, 8, got);
         ssel_high(m);
         chk({nm, "_rx_data"}, 32'(rx_of(m)), 32'hA5);
         chk({nm, "_miso_word"}, 32'(got), 32'h3C);
         chk({nm, "_rx_valid_n"}, 32'(rxv_cnt[m] - s_rxv), 32'd1);
         chk({nm, "_frame_end_n"}, 32'(fe_cnt[m] - s_fe), 32'd1);
         chk({nm, "_underrun_n"}, 32'(ur_cnt[m] - s_ur), 32'd0);
         chk({nm, "_idle_oe"}, 32'(miso_oe[m]), 32'd0);
      end

      // 16-bit LSB-first
      push_tx(4, 16'hBEEF);
      snap(4);
      ssel_low(4);
      spi_word(4, 16'h1234, 16, got);
      ssel_high(4);
      chk("w16_rx_data", 32'(rx_of(4)), 32'h1234);
      chk("w16_miso_word", 32'(got), 32'hBEEF);
      chk("w16_rx_valid_n", 32'(rxv_cnt[4] - s_rxv), 32'd1);

      // two words, one tx word supplied (modes 0 and 1)
      for (int m = 0; m < 2; m++) begin
         nm = $sformatf("m%0d", m);
         push_tx(m, 16'h0096);
         snap(m);
         ssel_low(m);
         spi_word(m, 16'h0011, 8, got);
         spi_word(m, 16'h0022, 8, got2);
         ssel_high(m);
         chk({nm, "_2w_first"}, 32'(got), 32'h96);
         chk({nm, "_2w_second"}, 32'(got2), 32'h00);
         chk({nm, "_2w_underrun_n"}, 32'(ur_cnt[m] - s_ur), 32'd1);
         chk({nm, "_2w_rx_valid_n"}, 32'(rxv_cnt[m] - s_rxv), 32'd2);
         chk({nm, "_2w_rx_data"}, 32'(rx_of(m)), 32'h22);
      end

      // abort after 5 bits, then a full frame
      push_tx(0, 16'h005A);
      snap(0);
      ssel_low(0);
      spi_word(0, 16'h00FF, 5, got);
      ssel_high(0);
      chk("abort_rx_valid_n", 32'(rxv_cnt[0] - s_rxv), 32'd0);
      chk("abort_frame_end_n", 32'(fe_cnt[0] - s_fe), 32'd1);
      chk("abort_rx_data_kept", 32'(rx_of(0)), 32'h22);
      push_tx(0, 16'h00C3);
      snap(0);
      ssel_low(0);
      spi_word(0, 16'h003E, 8, got);
      ssel_high(0);
      chk("after_abort_rx", 32'(rx_of(0)), 32'h3E);
      chk("after_abort_miso", 32'(got), 32'hC3);
      chk("after_abort_rx_valid_n", 32'(rxv_cnt[0] - s_rxv), 32'd1);

      // last sample edge and ssel release in the same instant
      push_tx(0, 16'h0081);
      snap(0);
      ssel_low(0);
      spi_word(0, 16'h006B, 7, got);
      mosi[0] = 1'b1;
      #(HALF);
      sck[0]  = 1'b1;
      ssel[0] = 1'b1;
      #(HALF);
      sck[0]  = 1'b0;
      repeat (10) @(negedge clk);
      chk("simul_rx_data", 32'(rx_of(0)), 32'h6B);
      chk("simul_rx_valid_n", 32'(rxv_cnt[0] - s_rxv), 32'd1);
      chk("simul_frame_end_n", 32'(fe_cnt[0] - s_fe), 32'd1);
      chk("simul_order", 32'(last_fe_cyc[0] > last_rxv_cyc[0]), 32'd1);

      // reset in the middle of a word
      push_tx(0, 16'h0077);
      snap(0);
      ssel_low(0);
      spi_word(0, 16'h00F0, 4, got);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rx_data", 32'(rx_of(0)), 32'h0);
      chk("midrst_miso_oe", 32'(miso_oe[0]), 32'd0);
      chk("midrst_miso", 32'(miso[0]), 32'd0);
      chk("midrst_tx_ready", 32'(tx_ready[0]), 32'd1);
      chk("midrst_strobes", 32'({rx_valid[0], tx_underrun[0], frame_end[0]}), 32'd0);
      rst = 1'b0;
      spi_word(0, 16'h00F0, 4, got);
      ssel_high(0);
      chk("midrst_no_rx_valid", 32'(rxv_cnt[0] - s_rxv), 32'd0);
      chk("midrst_no_frame_end", 32'(fe_cnt[0] - s_fe), 32'd0);
      push_tx(0, 16'h0042);
      snap(0);
      ssel_low(0);
      spi_word(0, 16'h0099, 8, got);
      ssel_high(0);
      chk("postrst_rx", 32'(rx_of(0)), 32'h99);
      chk("postrst_miso", 32'(got), 32'h42);
      chk("postrst_rx_valid_n", 32'(rxv_cnt[0] - s_rxv), 32'd1);
      chk("postrst_frame_end_n", 32'(fe_cnt[0] - s_fe), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
